dmem_rr_arbiter: RTL

//  Shares one dist_mem_gen_0 instance (sync write, async read on spo) between two requesters.

---
 rtl/dmem_rr_arbiter_pkg.sv | 16 +
 rtl/dmem_rr_arbiter_rr_arb2.sv | 20 ++
 rtl/dmem_rr_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/dmem_rr_arbiter_pkg.sv
// Shared types and helpers for the two-requester distributed-memory arbiter.
package dmem_rr_arbiter_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } arb_state_e;

    // Number of words addressable with an aw-bit address.
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; last_gnt is the index granted most recently.
module rr_arb2
    import dmem_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_gnt,
    output logic [NUM_REQ-1:0] gnt_c
);

    always_comb begin
        gnt_c = '0;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = last_gnt ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Clears a shared async-read memory after reset, then round-robin arbitrates
// single-cycle accesses from two requesters onto it.
module dmem_rr_arbiter
    import dmem_rr_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DATA_W         = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  init_done,
    output logic [ADDR_W-1:0]     mem_a,
    output logic [DATA_W-1:0]     mem_d,
    output logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_spo
);

    localparam int unsigned       DEPTH     = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);
    localparam arb_state_e        RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_ARB;

    arb_state_e          state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                last_gnt;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic                win;

    rr_arb2 u_rr_arb2 (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt_c    (arb_gnt)
    );

    // Memory port mux: clear writes during INIT, winner's access during ARB.
    always_comb begin
        gnt    = '0;
        win    = 1'b0;
        mem_we = 1'b0;
        mem_a  = '0;
        mem_d  = '0;
        if (state == ST_INIT) begin
            mem_we = 1'b1;
            mem_a  = clr_cnt;
        end else begin
            gnt = arb_gnt;
            win = arb_gnt[1];
            if (|arb_gnt) begin
                mem_we = we[win];
                mem_a  = win ? addr1  : addr0;
                mem_d  = win ? wdata1 : wdata0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            clr_cnt   <= '0;
            last_gnt  <= 1'b1;
            rvalid    <= '0;
            rdata     <= '0;
            init_done <= 1'(!CLEAR_ON_RESET);
        end else begin
            case (state)
                ST_INIT: begin
                    rvalid <= '0;
                    // Leave at the last word so clr_cnt never wraps.
                    if (clr_cnt == CLR_LAST) begin
                        state     <= ST_ARB;
                        init_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                ST_ARB: begin
                    rvalid <= '0;
                    if (|gnt) begin
                        last_gnt <= win;
                        if (!we[win]) begin
                            rdata  <= mem_spo;
                            rvalid <= win ? 2'b10 : 2'b01;
                        end
                    end
                end
            endcase
        end
    end

endmodule
